// File: rtl/fp_hs_pkg.sv
// Shared types and helpers for the stb/ack
// operand issuer and its result FIFO.
package fp_hs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } hs_state_t;

   localparam int DONE_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fp_op_issuer_if.sv
// Two-operand stb/ack bus between the issuer
// and an arithmetic unit.
interface fp_op_issuer_if #(
   parameter int DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  op_a_stb;
   logic                  op_b_stb;
   logic                  op_a_ack;
   logic                  op_b_ack;
   logic [DATA_WIDTH-1:0] op_z;
   logic                  op_z_stb;
   logic                  op_z_ack;

   modport master (
      output op_a, op_b,
      output op_a_stb, op_b_stb,
      input  op_a_ack, op_b_ack,
      input  op_z, op_z_stb,
      output op_z_ack
   );

   modport slave (
      input  op_a, op_b,
      input  op_a_stb, op_b_stb,
      output op_a_ack, op_b_ack,
      output op_z, op_z_stb,
      input  op_z_ack
   );

endinterface

// File: rtl/hs_result_fifo.sv
// Small circular result buffer; head reads
// as zero while empty.
module hs_result_fifo
   import fp_hs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RES_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [clog2(RES_DEPTH+1)-1:0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int CW = clog2(RES_DEPTH + 1);
   localparam int AW =
      (RES_DEPTH > 1) ? clog2(RES_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [RES_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [AW-1:0] nxt(
      input logic [AW-1:0] p
   );
      return (p == AW'(RES_DEPTH - 1)) ?
         '0 : p + 1'b1;
   endfunction

   assign full     = (count == CW'(RES_DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(do_push)
                        - CW'(do_pop);
      end
   end

   // Storage write on push
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RES_DEPTH; i++)
            mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/fp_op_issuer.sv
// Issues operand pairs to an stb/ack unit and
// queues its results for downstream.
module fp_op_issuer
   import fp_hs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RES_DEPTH  = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   fp_op_issuer_if.master        unit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [DONE_W-1:0]     done_count
);

   localparam int CW = clog2(RES_DEPTH + 1);
   localparam int TW = clog2(TIMEOUT + 1);

   hs_state_t     state;
   logic          a_done;
   logic          b_done;
   logic          a_nxt;
   logic          b_nxt;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] fcount;
   logic          f_full;
   logic          f_empty;
   logic          z_fire;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign unit.op_a_stb =
      (state == ISSUE) && !a_done;
   assign unit.op_b_stb =
      (state == ISSUE) && !b_done;
   assign unit.op_z_ack = (state == WAIT) &&
      (fcount < CW'(RES_DEPTH));
   assign z_fire    = unit.op_z_stb && unit.op_z_ack;
   assign out_valid = !f_empty;
   assign a_nxt     = a_done || unit.op_a_ack;
   assign b_nxt     = b_done || unit.op_b_ack;

   // Transaction FSM: accept, issue, collect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         unit.op_a  <= '0;
         unit.op_b  <= '0;
         done_count <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               unit.op_a <= in_a;
               unit.op_b <= in_b;
               a_done    <= 1'b0;
               b_done    <= 1'b0;
               state     <= ISSUE;
            end
            ISSUE: begin
               a_done <= a_nxt;
               b_done <= b_nxt;
               if (a_nxt && b_nxt) state <= WAIT;
            end
            WAIT: if (z_fire) begin
               done_count <= done_count + 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Per-transaction watchdog, frozen on full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt        <= '0;
         err_timeout <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) tcnt <= '0;
      end else if (!f_full &&
                   tcnt != TW'(TIMEOUT)) begin
         tcnt <= tcnt + 1'b1;
         if (tcnt == TW'(TIMEOUT - 1))
            err_timeout <= 1'b1;
      end
   end

   hs_result_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RES_DEPTH  (RES_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (z_fire),
      .pop       (out_valid && out_ready),
      .push_data (unit.op_z),
      .pop_data  (out_data),
      .count     (fcount),
      .full      (f_full),
      .empty     (f_empty)
   );

endmodule

// File: doc/fp_op_issuer.md
# fp_op_issuer

Initiator for the two-operand stb/ack handshake used by the floating-point `multiplier` and `adder` units. It accepts operand pairs on a valid/ready stream and drives `input_a`/`input_b` with their strobes. It then collects `output_z` by acknowledging the unit and delivers the results downstream through a small result FIFO. It sits between the systolic-array feeder logic and any stb/ack arithmetic core, such as a MAC stage.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `RES_DEPTH`, 2, result FIFO entries (≥1)
- `TIMEOUT`, 255, cycles per transaction before `err_timeout` sets
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: issuer can accept a pair
- `in_a`, `in_b` in DATA_WIDTH: operands
- `op_a`, `op_b` out DATA_WIDTH: operands to unit (registered)
- `op_a_stb`, `op_b_stb` out 1: operand strobes
- `op_a_ack`, `op_b_ack` in 1: unit operand acks
- `op_z` in DATA_WIDTH: unit result
- `op_z_stb` in 1: result strobe
- `op_z_ack` out 1: result ack
- `out_valid` out 1: result available
- `out_ready` in 1: downstream accepts
- `out_data` out DATA_WIDTH: FIFO head
- `busy` out 1: state ≠ IDLE
- `err_timeout` out 1: sticky timeout flag
- `done_count` out 16: completed transactions, wraps

## Operation
- FSM states are IDLE, ISSUE and WAIT. Exactly one transaction is outstanding at a time.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&&in_ready`, register `in_a`/`in_b` into `op_a`/`op_b`, clear `a_done`/`b_done` and the timeout counter, and go to ISSUE.
- ISSUE:
  - `op_a_stb = !a_done` and `op_b_stb = !b_done`.
  - A transfer occurs on an edge where stb and ack are both high. That edge sets the corresponding done bit.
  - `op_a`/`op_b` stay stable until their transfer.
  - Go to WAIT once both done bits are set. This includes both acks arriving on the same edge, or one arriving together with the earlier one's completion.
- WAIT:
  - `op_z_ack = (fifo_count < RES_DEPTH)`, computed from the registered count.
  - On `op_z_stb&&op_z_ack`, push `op_z`, increment `done_count` (modulo 2^16) and go to IDLE.
- Result FIFO:
  - `out_valid = count≠0` and `out_data` = head.
  - Pop on `out_valid&&out_ready`.
  - Simultaneous push and pop leaves count unchanged.
  - A pop while full does not enable a push in the same cycle.
- Timeout:
  - The counter increments each cycle in ISSUE, and in WAIT while `op_z_ack=1`. It freezes while the FIFO is full.
  - Reaching TIMEOUT sets `err_timeout`, which stays set until reset.
  - The transaction is not aborted. Strobes and acks continue per protocol.
  - The counter saturates at TIMEOUT.
- Reset (`rst` low, at any time including mid-transaction):
  - State goes to IDLE, FIFO empties, and done bits clear.
  - All outputs are 0 except `in_ready=1`.
  - An in-flight unit transaction is abandoned. The unit shares `rst` and resets with the issuer.

## Timing
- Input accepted at edge N → `op_a_stb`/`op_b_stb` high in cycle N+1.
- With acks in N+1 → strobes low in N+2, state WAIT in N+2.
- `op_z` captured at edge M → `out_valid` high in M+1 and `in_ready` high in M+1.
- Minimum issue-to-issue interval is 3 cycles plus unit latency.
- `in_ready`, `op_*_stb`, `op_z_ack`, `busy` and `out_valid` are decoded from registers only. There is no combinational path from any input to any output.

## Structure
- Shared package `fp_hs_pkg` holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - the `clog2` function for FIFO and timeout counter widths;
  - the `done_count` width constant (16).
- One sub-module, `hs_result_fifo`:
  - parameterised by DATA_WIDTH and RES_DEPTH;
  - ports: push/pop/data/count/full/empty;
  - same clock and asynchronous active-low reset.

## Test plan
- Basic multiply: `in_a`=0x40000000 (2.0), `in_b`=0x40400000 (3.0), unit acks immediately, returns `op_z`=0x40C00000 two cycles later → `out_data`=0x40C00000, `done_count`=1, `in_ready` high again.
- Skewed acks: `op_a_ack` in ISSUE cycle 1, `op_b_ack` in cycle 4 → `op_a_stb` drops after cycle 1, `op_b_stb` stays high through cycle 4, `op_b` stable throughout, WAIT entered after cycle 4.
- Backpressure: `out_ready`=0 with RES_DEPTH=2, three transactions → third result held with `op_z_ack`=0 and `in_ready`=0. Raising `out_ready` for one cycle → `op_z_ack`=1 the next cycle and the third result is captured.
- Timeout: TIMEOUT=8, unit never raises `op_z_stb` → `err_timeout`=1 after 8 counted cycles. A later `op_z_stb` still completes the transaction and `err_timeout` stays 1.
- Reset mid-transaction: assert `rst` low in ISSUE with `op_a_stb`=1 → strobes drop immediately (async), FIFO empty, `in_ready`=1, `done_count`=0.
- Counter wrap: 65536 back-to-back transactions → `done_count`=0 and no `err_timeout`.
